// File: rtl/lanza_cuenta_pkg.sv
// Shared types and constants for the lanza_cuenta initiator and its result file.
package lanza_cuenta_pkg;

  localparam int ANCHO_VALOR  = 3;
  localparam int ANCHO_CUENTA = 4;
  localparam int ANCHO_SUMA   = 7;
  localparam int N_RES        = 8;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    ARRANQUE = 3'd1,
    GUARDA   = 3'd2,
    ESPERA   = 3'd3,
    AVANZA   = 3'd4
  } estado_e;

  localparam logic [ANCHO_VALOR-1:0]  VALOR_ULTIMO   = 3'd7;
  localparam logic [ANCHO_CUENTA-1:0] CUENTA_TIMEOUT = 4'hF;

  // 8 x 15 = 120 fits in 7 bits, so the accumulation never wraps
  function automatic logic [ANCHO_SUMA-1:0] suma_mas(input logic [ANCHO_SUMA-1:0] s,
                                                      input logic [ANCHO_CUENTA-1:0] c);
    return s + {3'd0, c};
  endfunction

endpackage

// File: rtl/lanza_cuenta_banco.sv
// 8 x 4 result file: synchronous write, combinational read, cleared by async reset.
module lanza_cuenta_banco
  import lanza_cuenta_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [ANCHO_VALOR-1:0]  waddr_i,
  input  logic [ANCHO_CUENTA-1:0] wdata_i,
  input  logic [ANCHO_VALOR-1:0]  raddr_i,
  output logic [ANCHO_CUENTA-1:0] rdata_o
);

  logic [ANCHO_CUENTA-1:0] mem_q [N_RES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_RES; i++) mem_q[i] <= 4'd0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lanza_cuenta.sv
// Sweeps Valor 0..7 through the cuenta1 start/fin handshake, storing each result.
// Optional per-value timeout enabled by defining LANZA_CUENTA_TIMEOUT_EN.
module lanza_cuenta
  import lanza_cuenta_pkg::*;
#(
  parameter int ESPERA_MAX = 32,
  parameter int ANCHO_T    = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  output logic [ANCHO_VALOR-1:0]  Valor,
  output logic                    start,
  input  logic [ANCHO_CUENTA-1:0] Cuenta,
  input  logic                    fin,
  output logic                    ocupado,
  output logic                    hecho,
  output logic                    error,
  input  logic [ANCHO_VALOR-1:0]  sel,
  output logic [ANCHO_CUENTA-1:0] dato,
  output logic [ANCHO_SUMA-1:0]   suma
);

  estado_e                 estado_q;
  logic [ANCHO_VALOR-1:0]  valor_q;
  logic                    start_q;
  logic                    ocupado_q;
  logic                    hecho_q;
  logic                    error_q;
  logic [ANCHO_SUMA-1:0]   suma_q;
  logic                    timeout_s;
  logic                    we_s;
  logic [ANCHO_CUENTA-1:0] wdata_s;

`ifdef LANZA_CUENTA_TIMEOUT_EN
  localparam logic [ANCHO_T-1:0] T_ULTIMO = ANCHO_T'(ESPERA_MAX - 1);
  logic [ANCHO_T-1:0] t_q;

  // Counts cycles spent in ESPERA; cleared in GUARDA so each value starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
    end else if (estado_q == GUARDA) begin
      t_q <= '0;
    end else if ((estado_q == ESPERA) && !fin && !timeout_s) begin
      t_q <= t_q + 1'b1;
    end
  end

  assign timeout_s = (estado_q == ESPERA) && (t_q == T_ULTIMO);
`else
  assign timeout_s = 1'b0;
`endif

  // fin has priority over a coincident timeout
  assign we_s    = (estado_q == ESPERA) && (fin || timeout_s);
  assign wdata_s = fin ? Cuenta : CUENTA_TIMEOUT;

  lanza_cuenta_banco u_banco (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_s),
    .waddr_i (valor_q),
    .wdata_i (wdata_s),
    .raddr_i (sel),
    .rdata_o (dato)
  );

  // Run sequencer with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      valor_q   <= 3'd0;
      start_q   <= 1'b0;
      ocupado_q <= 1'b0;
      hecho_q   <= 1'b0;
      error_q   <= 1'b0;
      suma_q    <= 7'd0;
    end else begin
      start_q <= 1'b0;
      hecho_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          if (go) begin
            estado_q  <= ARRANQUE;
            start_q   <= 1'b1;
            ocupado_q <= 1'b1;
            valor_q   <= 3'd0;
            suma_q    <= 7'd0;
            error_q   <= 1'b0;
          end
        end
        ARRANQUE: estado_q <= GUARDA;
        GUARDA:   estado_q <= ESPERA;
        ESPERA: begin
          if (fin) begin
            suma_q   <= suma_mas(suma_q, Cuenta);
            estado_q <= AVANZA;
          end else if (timeout_s) begin
            error_q  <= 1'b1;
            estado_q <= AVANZA;
          end
        end
        AVANZA: begin
          if (valor_q != VALOR_ULTIMO) begin
            valor_q  <= valor_q + 3'd1;
            start_q  <= 1'b1;
            estado_q <= ARRANQUE;
          end else begin
            hecho_q   <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= REPOSO;
          end
        end
        default: begin
          estado_q  <= REPOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign Valor   = valor_q;
  assign start   = start_q;
  assign ocupado = ocupado_q;
  assign hecho   = hecho_q;
  assign error   = error_q;
  assign suma    = suma_q;

endmodule
